// File: rtl/atctlc2axi500_grant_ctrl.sv
// TL-D Grant/GrantData issue stage: allocates a sink from the pool, emits the D beats, and
// forwards E GrantAcks as registered deallocations. ATCTLC2AXI500_GRANT_PIPE_EN enables zero-bubble grants.
module atctlc2axi500_grant_ctrl #(
    parameter int SINK_WIDTH   = 3,
    parameter int SOURCE_WIDTH = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int BEAT_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    gnt_valid,
    output logic                    gnt_ready,
    input  logic [SOURCE_WIDTH-1:0] gnt_source,
    input  logic [1:0]              gnt_param,
    input  logic                    gnt_has_data,
    input  logic [BEAT_WIDTH-1:0]   gnt_beats_m1,
    input  logic                    gnt_denied,
    input  logic                    dat_valid,
    output logic                    dat_ready,
    input  logic [DATA_WIDTH-1:0]   dat_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [1:0]              d_param,
    output logic [SOURCE_WIDTH-1:0] d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic                    d_denied,
    output logic [DATA_WIDTH-1:0]   d_data,
    input  logic                    e_valid,
    output logic                    e_ready,
    input  logic [SINK_WIDTH-1:0]   e_sink,
    input  logic                    pool_busy,
    input  logic [SINK_WIDTH-1:0]   pool_next_sink,
    output logic                    pool_req_valid,
    output logic                    pool_rsp_valid,
    output logic [SINK_WIDTH-1:0]   pool_rsp_sink,
    output logic                    pool_ack_valid,
    output logic [SINK_WIDTH-1:0]   pool_ack_sink
);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t                  state, state_nxt;
    logic [SOURCE_WIDTH-1:0] source_q;
    logic [1:0]              param_q;
    logic                    has_data_q;
    logic                    denied_q;
    logic [BEAT_WIDTH-1:0]   beats_m1_q;
    logic [BEAT_WIDTH-1:0]   cnt_q;
    logic [SINK_WIDTH-1:0]   sink_q;
    logic                    accept;
    logic                    handshake;
    logic                    last_beat;

    always_comb begin
        state_nxt      = state;
        gnt_ready      = 1'b0;
        d_valid        = 1'b0;
        dat_ready      = 1'b0;
        d_data         = '0;
        pool_rsp_valid = 1'b0;
        handshake      = 1'b0;
        last_beat      = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                gnt_ready = ~pool_busy;
                accept    = gnt_valid & gnt_ready;
                if (accept) state_nxt = SEND;
            end
            SEND: begin
                d_valid        = has_data_q ? dat_valid : 1'b1;
                dat_ready      = has_data_q & d_ready;
                d_data         = has_data_q ? dat_data : '0;
                handshake      = d_valid & d_ready;
                // Compare before increment so a full 2**BEAT_WIDTH-beat grant never wraps early.
                last_beat      = handshake && (cnt_q == beats_m1_q);
                pool_rsp_valid = last_beat;
`ifdef ATCTLC2AXI500_GRANT_PIPE_EN
                gnt_ready      = last_beat & ~pool_busy;
`endif
                accept         = gnt_valid & gnt_ready;
                if (last_beat && !accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pool_req_valid = accept;
    assign pool_rsp_sink  = sink_q;
    assign d_opcode       = has_data_q ? 3'd5 : 3'd4;
    assign d_param        = param_q;
    assign d_source       = source_q;
    assign d_sink         = sink_q;
    assign d_denied       = denied_q;
    assign e_ready        = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            source_q   <= '0;
            param_q    <= '0;
            has_data_q <= 1'b0;
            denied_q   <= 1'b0;
            beats_m1_q <= '0;
            cnt_q      <= '0;
            sink_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                source_q   <= gnt_source;
                param_q    <= gnt_param;
                has_data_q <= gnt_has_data;
                denied_q   <= gnt_denied;
                beats_m1_q <= gnt_has_data ? gnt_beats_m1 : '0;
                sink_q     <= pool_next_sink;
                cnt_q      <= '0;
            end else if (handshake) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Registered so there is no combinational path from the E channel into allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            pool_ack_valid <= 1'b0;
            pool_ack_sink  <= '0;
        end else begin
            pool_ack_valid <= e_valid;
            pool_ack_sink  <= e_sink;
        end
    end

endmodule

// File: doc/atctlc2axi500_grant_ctrl.md
Name: atctlc2axi500_grant_ctrl

Overview:
- TL-D Grant/GrantData issue stage for the TL-C to AXI bridge, sitting directly in front of the sink ID pool.
- Accepts one grant command at a time and allocates a sink ID from the pool. It then emits the command's D-channel beats tagged with that sink.
- Marks the pool entry responded on the last beat. TL-E GrantAck is registered and returned to the pool as a deallocation.

Parameters:
SINK_WIDTH, 3, sink ID width; must equal the pool's SINK_WIDTH
SOURCE_WIDTH, 4, TL source ID width
DATA_WIDTH, 64, D-channel data width
BEAT_WIDTH, 3, beat counter width; max 2**BEAT_WIDTH beats per grant

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
gnt_valid  in  1  grant command valid
gnt_ready  out  1  grant command accept
gnt_source  in  SOURCE_WIDTH  TL source to answer
gnt_param  in  2  cap permission (toT/toB/toN)
gnt_has_data  in  1  1=GrantData, 0=Grant
gnt_beats_m1  in  BEAT_WIDTH  beat count minus 1 (ignored when has_data=0)
gnt_denied  in  1  denied flag
dat_valid  in  1  data beat valid
dat_ready  out  1  data beat accept
dat_data  in  DATA_WIDTH  beat payload
d_valid  out  1  TL-D valid
d_ready  in  1  TL-D ready
d_opcode  out  3  4=Grant, 5=GrantData
d_param  out  2  latched gnt_param
d_source  out  SOURCE_WIDTH  latched source
d_sink  out  SINK_WIDTH  allocated sink
d_denied  out  1  latched denied
d_data  out  DATA_WIDTH  pass-through dat_data (0 for Grant)
e_valid  in  1  TL-E GrantAck valid
e_ready  out  1  constant 1
e_sink  in  SINK_WIDTH  acked sink
pool_busy  in  1  pool full
pool_next_sink  in  SINK_WIDTH  pool's next free sink
pool_req_valid  out  1  allocate pulse
pool_rsp_valid  out  1  responded pulse
pool_rsp_sink  out  SINK_WIDTH  responded sink
pool_ack_valid  out  1  deallocate pulse
pool_ack_sink  out  SINK_WIDTH  deallocated sink

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (reset).
- On reset:
  - State returns to IDLE and the beat counter clears to 0.
  - All valid-type outputs are 0; e_ready stays 1.
  - Latched fields and pool_ack_sink clear to 0.
  - Reset mid-grant abandons the grant with no rsp pulse. The pool must be reset together with this block.
- FSM states are IDLE and SEND.
- IDLE:
  - gnt_ready = ~pool_busy.
  - pool_req_valid = gnt_valid & gnt_ready, combinational, in the same cycle.
  - On accept: latch source, param, has_data, denied and beats_m1 (forced to 0 when has_data=0), capture pool_next_sink into the sink register, clear the counter, go to SEND.
  - d_valid = 0 and dat_ready = 0.
- SEND:
  - gnt_ready = 0.
  - Grant: d_valid = 1, d_data = 0.
  - GrantData: d_valid = dat_valid, dat_ready = d_ready, d_data = dat_data.
  - d_opcode/param/source/sink/denied come from registers and are stable while the grant is in flight.
  - On each D handshake (d_valid & d_ready), the counter increments.
  - Last beat is the handshake with counter == beats_m1. It asserts pool_rsp_valid = 1 in the same cycle, with pool_rsp_sink = sink register. FSM returns to IDLE.
- Latency:
  - Accept-to-first-d_valid is 1 cycle.
  - Without the optional feature, there is one IDLE cycle between consecutive grants.
- E channel:
  - e_ready is tied to 1.
  - pool_ack_valid <= e_valid and pool_ack_sink <= e_sink, both registered with 1-cycle latency. A freed sink is therefore visible as pool_next_sink 2 cycles after the E beat at the earliest.
- Pool full: gnt_ready stays 0 until pool_busy drops. There is no combinational path from e_valid to gnt_ready.
- Simultaneous events:
  - Ack and allocate in the same cycle are independent; the pool resolves them.
  - An ack for the sink currently in SEND is forwarded unchanged (protocol violation, not checked here).
- Wrap-around: beats_m1 = 2**BEAT_WIDTH-1 gives a full-count grant. The counter compares before incrementing, so there is no overflow ambiguity.
- Backpressure: d_ready low holds all d_* outputs and the counter unchanged.

Optional Feature:
- Macro: ATCTLC2AXI500_GRANT_PIPE_EN.
- Defined:
  - In SEND, gnt_ready = last-beat-handshake & ~pool_busy.
  - A new grant is accepted in the last-beat cycle; the FSM stays in SEND and reloads the latches and counter.
  - pool_req_valid and pool_rsp_valid may both be 1 in that cycle.
  - Result: zero bubble between grants.
- Undefined: the behaviour above, with one bubble cycle.

Test Plan:
- Reset, then a Grant with source=3, param=1, pool_next_sink=5.
  -> pool_req_valid pulses in the accept cycle.
  -> Next cycle: d_valid=1, d_opcode=4, d_sink=5, d_source=3.
  -> With d_ready=1: pool_rsp_valid=1, rsp_sink=5 in that cycle; FSM back in IDLE.
- GrantData with beats_m1=3, data 0xA0..0xA3, d_ready toggled 1,0,1,1,0,1.
  -> 4 D beats in order, with d_* held during stalls.
  -> pool_rsp_valid exactly once, on beat 0xA3.
- pool_busy=1 with gnt_valid=1 for 5 cycles.
  -> gnt_ready=0 and pool_req_valid=0 throughout.
  -> Drop busy: accept in the same cycle.
- e_valid=1 with e_sink=6 at cycle N.
  -> pool_ack_valid=1, pool_ack_sink=6 at N+1 only.
- Two back-to-back Grants.
  -> Without the macro: d_valid gap of 1 cycle.
  -> With ATCTLC2AXI500_GRANT_PIPE_EN: gap of 0, with req and rsp pulses coincident.
- Assert reset in SEND mid-beat 1 of 4.
  -> Next cycle: all valid outputs are 0 and no pool_rsp_valid pulse occurs.
